// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction memory geometry and the loader's
// sequencer state encodings, also used by the core's control and decoder.
package proc_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_KICK = 3'd2,
        ST_RUN  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear and enable.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             EN,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    // Count while enabled, holding at the maximum value instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_q <= '0;
        end else if (EN && (r_q != '1)) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/prog_loader.sv
// Host-side program loader: streams instruction words into instruction memory
// from address 0, kicks the core with a one-cycle START, then times the run
// until the core reports RDY.
module prog_loader #(
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_VALID,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic              LD_READY,
    output logic              MEM_WEN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic              CORE_START,
    input  logic              CORE_RDY,
    output logic              DONE,
    output logic              OVF,
    output logic [CNT_W-1:0]  RUN_CYCLES
);

    import proc_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W:0]   w_wcnt_inc;
    logic              w_acc;
    logic              w_top;
    logic              w_clr;
    logic              w_set_ovf;
    logic              w_run;
    logic              r_ready;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_start;
    logic              r_done;
    logic              r_ovf;
    logic [CNT_W-1:0]  w_run_cycles;

    assign w_acc      = LD_VALID && r_ready;
    assign w_wcnt_inc = r_wcnt + (ADDR_W + 1)'(1);
    // Carry into the extra bit means the word being written sits at the top address.
    assign w_top      = w_wcnt_inc[ADDR_W];
    assign w_run      = (r_state == ST_RUN);

    // Next-state decode plus the clear/overflow strobes that go with each transition.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_set_ovf   = 1'b0;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (w_acc) begin
                    w_clr       = 1'b1;
                    w_state_nxt = LD_LAST ? ST_KICK : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_acc) begin
                    if (LD_LAST) begin
                        w_state_nxt = ST_KICK;
                    end else if (w_top) begin
                        w_state_nxt = ST_KICK;
                        w_set_ovf   = 1'b1;
                    end
                end
            end
            // KICK spans two cycles: the first lets the final write commit,
            // the second carries the registered START pulse.
            ST_KICK: begin
                if (r_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (CORE_RDY) begin
                    w_state_nxt = ST_FIN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, write address counter and sticky status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ready <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wcnt  <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD) ||
                       (w_state_nxt == ST_FIN);
            r_wen   <= w_acc;
            if (w_acc) begin
                r_data <= LD_DATA;
                if (r_state == ST_LOAD) begin
                    r_addr <= r_wcnt[ADDR_W-1:0];
                    r_wcnt <= w_wcnt_inc;
                end else begin
                    r_addr <= '0;
                    r_wcnt <= (ADDR_W + 1)'(1);
                end
            end
            r_start <= (r_state == ST_KICK) && !r_start;
            if (w_clr) begin
                r_done <= 1'b0;
            end else if (w_run && CORE_RDY) begin
                r_done <= 1'b1;
            end
            if (w_clr) begin
                r_ovf <= 1'b0;
            end else if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_run_cnt (
        .CLK (CLK),
        .RST (RST),
        .CLR (w_clr),
        .EN  (w_run),
        .Q   (w_run_cycles)
    );

    assign LD_READY   = r_ready;
    assign MEM_WEN    = r_wen;
    assign MEM_ADDR   = r_addr;
    assign MEM_DATA   = r_data;
    assign CORE_START = r_start;
    assign DONE       = r_done;
    assign OVF        = r_ovf;
    assign RUN_CYCLES = w_run_cycles;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load/kick/run sequences with hand-computed results.
module tb_prog_loader;

    logic        CLK;
    logic        RST;
    logic        LD_VALID;
    logic [15:0] LD_DATA;
    logic        LD_LAST;
    logic        LD_READY;
    logic        MEM_WEN;
    logic [11:0] MEM_ADDR;
    logic [15:0] MEM_DATA;
    logic        CORE_START;
    logic        CORE_RDY;
    logic        DONE;
    logic        OVF;
    logic [15:0] RUN_CYCLES;

    int unsigned n_total;
    int unsigned n_bad;
    int unsigned start_cnt;
    logic [27:0] wr_q[$];

    prog_loader #(
        .ADDR_W(12),
        .DATA_W(16),
        .CNT_W (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LD_VALID   (LD_VALID),
        .LD_DATA    (LD_DATA),
        .LD_LAST    (LD_LAST),
        .LD_READY   (LD_READY),
        .MEM_WEN    (MEM_WEN),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .CORE_START (CORE_START),
        .CORE_RDY   (CORE_RDY),
        .DONE       (DONE),
        .OVF        (OVF),
        .RUN_CYCLES (RUN_CYCLES)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Log memory writes and START pulses shortly after each rising edge.
    always begin
        @(posedge CLK);
        #2;
        if (MEM_WEN === 1'b1) wr_q.push_back({MEM_ADDR, MEM_DATA});
        if (CORE_START === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Present one word and wait (bounded) until it is handshaken; returns at the
    // falling edge after the accepting rising edge.
    task automatic send(input logic [15:0] d, input logic last);
        int unsigned n;
        n = 0;
        LD_VALID = 1'b1;
        LD_DATA  = d;
        LD_LAST  = last;
        while (LD_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (LD_READY !== 1'b1) begin
            check("send_timeout", {31'b0, LD_READY}, 32'd1);
        end else begin
            @(posedge CLK);
            @(negedge CLK);
        end
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
    endtask

    initial begin
        int unsigned s0;
        int unsigned n0;
        n_total   = 0;
        n_bad     = 0;
        start_cnt = 0;
        RST       = 1'b1;
        LD_VALID  = 1'b0;
        LD_DATA   = '0;
        LD_LAST   = 1'b0;
        CORE_RDY  = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_ready", {31'b0, LD_READY}, 32'd0);
        check("rst_wen",   {31'b0, MEM_WEN}, 32'd0);
        check("rst_start", {31'b0, CORE_START}, 32'd0);
        check("rst_done",  {31'b0, DONE}, 32'd0);
        check("rst_ovf",   {31'b0, OVF}, 32'd0);
        check("rst_addr",  {20'b0, MEM_ADDR}, 32'd0);
        check("rst_data",  {16'b0, MEM_DATA}, 32'd0);
        check("rst_cyc",   {16'b0, RUN_CYCLES}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_ready", {31'b0, LD_READY}, 32'd1);

        // Three back-to-back words, then a 5-cycle run
        send(16'h1234, 1'b0);
        check("t1_wen0", {31'b0, MEM_WEN}, 32'd1);
        check("t1_a0", {20'b0, MEM_ADDR}, 32'h000);
        send(16'h5678, 1'b0);
        check("t1_a1", {20'b0, MEM_ADDR}, 32'h001);
        send(16'h9ABC, 1'b1);
        check("t1_a2", {20'b0, MEM_ADDR}, 32'h002);
        check("t1_d2", {16'b0, MEM_DATA}, 32'h9ABC);
        check("t1_rdy_drop", {31'b0, LD_READY}, 32'd0);
        check("t1_start_k", {31'b0, CORE_START}, 32'd0);
        @(negedge CLK);
        check("t1_start_k1", {31'b0, CORE_START}, 32'd1);
        check("t1_wen_k1", {31'b0, MEM_WEN}, 32'd0);
        @(negedge CLK);
        check("t1_start_k2", {31'b0, CORE_START}, 32'd0);
        repeat (4) @(negedge CLK);
        CORE_RDY = 1'b1;
        @(negedge CLK);
        CORE_RDY = 1'b0;
        check("t1_done", {31'b0, DONE}, 32'd1);
        check("t1_cyc", {16'b0, RUN_CYCLES}, 32'd5);
        check("t1_ready", {31'b0, LD_READY}, 32'd1);
        check("t1_ovf", {31'b0, OVF}, 32'd0);
        check("t1_nstart", start_cnt, 32'd1);
        check("t1_nwr", wr_q.size(), 32'd3);
        check("t1_w0", {4'b0, wr_q[0]}, {4'b0, 12'h000, 16'h1234});
        check("t1_w1", {4'b0, wr_q[1]}, {4'b0, 12'h001, 16'h5678});
        check("t1_w2", {4'b0, wr_q[2]}, {4'b0, 12'h002, 16'h9ABC});
        @(negedge CLK);
        check("t1_done_hold", {31'b0, DONE}, 32'd1);

        // Gapped handshakes and a word offered during RUN
        wr_q.delete();
        send(16'h1111, 1'b0);
        check("t2_done_clr", {31'b0, DONE}, 32'd0);
        check("t2_cyc_clr", {16'b0, RUN_CYCLES}, 32'd0);
        repeat (2) @(negedge CLK);
        send(16'h2222, 1'b0);
        @(negedge CLK);
        send(16'h3333, 1'b1);
        LD_VALID = 1'b1;
        LD_DATA  = 16'hDEAD;
        repeat (6) @(negedge CLK);
        LD_VALID = 1'b0;
        CORE_RDY = 1'b1;
        @(negedge CLK);
        CORE_RDY = 1'b0;
        check("t2_nwr", wr_q.size(), 32'd3);
        check("t2_w0", {4'b0, wr_q[0]}, {4'b0, 12'h000, 16'h1111});
        check("t2_w1", {4'b0, wr_q[1]}, {4'b0, 12'h001, 16'h2222});
        check("t2_w2", {4'b0, wr_q[2]}, {4'b0, 12'h002, 16'h3333});
        check("t2_done", {31'b0, DONE}, 32'd1);
        check("t2_cyc", {16'b0, RUN_CYCLES}, 32'd5);

        // 4096 words without LAST: overflow at the top address
        wr_q.delete();
        s0 = start_cnt;
        for (int unsigned i = 0; i < 4096; i++) begin
            send(16'(i) ^ 16'hA5A5, 1'b0);
        end
        check("t3_ovf", {31'b0, OVF}, 32'd1);
        check("t3_ready", {31'b0, LD_READY}, 32'd0);
        LD_VALID = 1'b1;
        LD_DATA  = 16'hBEEF;
        repeat (4) @(negedge CLK);
        LD_VALID = 1'b0;
        n0 = 0;
        foreach (wr_q[j]) if (wr_q[j][27:16] == 12'h000) n0++;
        check("t3_nwr", wr_q.size(), 32'd4096);
        check("t3_last", {4'b0, wr_q[4095]}, {4'b0, 12'hFFF, 16'h0FFF ^ 16'hA5A5});
        check("t3_addr0", n0, 32'd1);
        check("t3_start", start_cnt - s0, 32'd1);
        CORE_RDY = 1'b1;
        @(negedge CLK);
        CORE_RDY = 1'b0;
        check("t3_done", {31'b0, DONE}, 32'd1);
        check("t3_ovf_hold", {31'b0, OVF}, 32'd1);

        // Reset in the middle of a load, then a one-word program
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check("t4_wen", {31'b0, MEM_WEN}, 32'd0);
        check("t4_ready", {31'b0, LD_READY}, 32'd0);
        check("t4_addr", {20'b0, MEM_ADDR}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("t4_ready1", {31'b0, LD_READY}, 32'd1);
        wr_q.delete();
        send(16'h00FF, 1'b1);
        check("t4_nwr", wr_q.size(), 32'd1);
        check("t4_w0", {4'b0, wr_q[0]}, {4'b0, 12'h000, 16'h00FF});
        check("t4_done", {31'b0, DONE}, 32'd0);
        check("t4_ovf", {31'b0, OVF}, 32'd0);
        check("t4_cyc", {16'b0, RUN_CYCLES}, 32'd0);
        repeat (2) @(negedge CLK);
        CORE_RDY = 1'b1;
        @(negedge CLK);
        CORE_RDY = 1'b0;
        check("t4_cyc1", {16'b0, RUN_CYCLES}, 32'd1);
        check("t4_done1", {31'b0, DONE}, 32'd1);

        // RDY outside RUN is ignored; long run saturates the cycle counter
        send(16'h0101, 1'b0);
        CORE_RDY = 1'b1;
        @(negedge CLK);
        CORE_RDY = 1'b0;
        check("t5_done_load", {31'b0, DONE}, 32'd0);
        send(16'h0202, 1'b1);
        CORE_RDY = 1'b1;
        repeat (2) @(negedge CLK);
        CORE_RDY = 1'b0;
        check("t5_done_kick", {31'b0, DONE}, 32'd0);
        check("t5_cyc0", {16'b0, RUN_CYCLES}, 32'd0);
        repeat (70000) @(negedge CLK);
        check("t5_sat", {16'b0, RUN_CYCLES}, 32'hFFFF);
        check("t5_busy", {31'b0, DONE}, 32'd0);
        CORE_RDY = 1'b1;
        @(negedge CLK);
        CORE_RDY = 1'b0;
        check("t5_done", {31'b0, DONE}, 32'd1);
        check("t5_sat_hold", {16'b0, RUN_CYCLES}, 32'hFFFF);
        check("t5_ready", {31'b0, LD_READY}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
